// File: rtl/mips32_dump_pkg.sv
// Shared types and constants for the data-memory dump engine.
package mips32_dump_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = 2;
  localparam bit          MSB_FIRST      = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } state_e;

  // Byte currently presented from a word held in the shift register.
  function automatic logic [BYTE_W-1:0] head_byte(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
  endfunction

  // Advance the shift register by one byte, filling with zeros.
  function automatic logic [WORD_W-1:0] shift_out(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? {w[WORD_W-BYTE_W-1:0], BYTE_W'(0)}
                     : {BYTE_W'(0), w[WORD_W-1:BYTE_W]};
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits one loaded 32-bit word into four bytes on a valid/ready stream.
module word_serializer
  import mips32_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_last_word,
  input  logic              i_ready,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_word_done_c
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(BYTES_PER_WORD - 2);

  logic [WORD_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic              r_last_word;
  logic              r_last;
  logic              w_xfer;

  assign w_xfer        = r_valid && i_ready;
  assign o_word_done_c = w_xfer && (r_idx == LAST_IDX);

  // Everything holds while stalled; only a transfer advances the byte index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_last_word <= 1'b0;
      r_last      <= 1'b0;
    end else if (i_load) begin
      r_shift     <= i_word;
      r_idx       <= '0;
      r_valid     <= 1'b1;
      r_last_word <= i_last_word;
      r_last      <= 1'b0;
    end else if (w_xfer) begin
      r_shift <= shift_out(r_shift);
      r_idx   <= r_idx + IDX_W'(1);
      r_valid <= (r_idx != LAST_IDX);
      r_last  <= r_last_word && (r_idx == PEN_IDX);
    end
  end

  assign o_data  = head_byte(r_shift);
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/mem_dump_reader.sv
// Walks a wrapping word-address range of data memory and streams it out byte-wise.
module mem_dump_reader
  import mips32_dump_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_first_addr,
  input  logic [ADDR_WIDTH-1:0] i_last_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd_en,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [7:0]            o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_done
);

  // One extra bit so a full-memory dump count of 2^ADDR_WIDTH fits.
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] w_span;
  logic                  w_load;
  logic                  w_last_word;
  logic                  w_word_done;

  assign w_span      = i_last_addr - i_first_addr;
  assign w_load      = (r_state == WAIT);
  assign w_last_word = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr  <= i_first_addr;
            r_cnt   <= CNT_W'(w_span) + CNT_W'(1);
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= READ;
          end
        end
        READ: r_state <= WAIT;
        WAIT: r_state <= SEND;
        SEND: begin
          if (w_word_done) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_last_word) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= READ;
              r_rd_en <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  word_serializer u_ser (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_word       (WORD_W'(i_mem_rdata)),
    .i_last_word  (w_last_word),
    .i_ready      (i_out_ready),
    .o_data       (o_out_data),
    .o_valid      (o_out_valid),
    .o_last       (o_out_last),
    .o_word_done_c(w_word_done)
  );

  assign o_mem_addr  = r_addr;
  assign o_mem_rd_en = r_rd_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of dumps, random dumps, restart and mid-word reset.
module tb_mem_dump_reader;

  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;
  localparam int          NW     = 32;
  localparam int          BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_first_addr;
  logic [AW-1:0] i_last_addr;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd_en;
  logic [DW-1:0] i_mem_rdata = '0;
  logic [7:0]    o_out_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          o_out_last;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_first_addr(i_first_addr),
    .i_last_addr (i_last_addr),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rd_en (o_mem_rd_en),
    .i_mem_rdata (i_mem_rdata),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_last  (o_out_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  // Data memory: read data valid the cycle after the strobe.
  logic [DW-1:0] mem [NW];
  always @(posedge clk) if (o_mem_rd_en) i_mem_rdata <= mem[o_mem_addr];

  int checks   = 0;
  int failures = 0;

  logic [7:0]    got_q[$];
  logic [AW-1:0] rd_q[$];
  int done_cnt, done_cyc, last_cnt, last_idx, stall_err, proto_err, first_valid, first_rd;
  bit timed_out;

  typedef struct {
    logic [AW-1:0] f;
    logic [AW-1:0] l;
    int            mode;       // 0 ready=1, 1 toggle 1/0, 2 random
    int            restart_at; // cycle of an extra start pulse, 0 = none
    int            mem_init;   // 0 mem[i]=i, 1 mem[i]=i+1 with mem[3]=DEADBEEF
    int            exp_words;
    int            exp_done;   // 0 = not checked
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                          input int restart_at, input int abort_after);
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    got_q.delete();
    rd_q.delete();
    done_cnt = 0; done_cyc = 0; last_cnt = 0; last_idx = -1;
    stall_err = 0; proto_err = 0; first_valid = 0; first_rd = 0;
    timed_out = 1'b1; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    i_first_addr = f;
    i_last_addr  = l;
    i_start      = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      i_start = (c == restart_at);
      if (c == restart_at) begin
        i_first_addr = AW'(0);
        i_last_addr  = AW'(NW - 1);
      end
      case (mode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (c % 2) == 1;
        default: i_out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (o_mem_rd_en) begin
        rd_q.push_back(o_mem_addr);
        if (first_rd == 0) first_rd = c;
      end
      if (prev_stall && (o_out_valid !== 1'b1 || o_out_data !== prev_data || o_out_last !== prev_last))
        stall_err++;
      if (o_out_valid && o_busy !== 1'b1) proto_err++;
      if (o_out_last && !o_out_valid) proto_err++;
      if (o_out_valid && first_valid == 0) first_valid = c;
      if (o_out_valid && i_out_ready) begin
        got_q.push_back(o_out_data);
        if (o_out_last) begin
          last_cnt++;
          last_idx = got_q.size() - 1;
        end
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_data  = o_out_data;
      prev_last  = o_out_last;
      if (o_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        if (o_busy) proto_err++;
      end
      if (abort_after > 0 && got_q.size() == abort_after) begin
        timed_out = 1'b0;
        break;
      end
      if (done_cyc != 0 && c > done_cyc) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Reference: the dump is the words first..last (wrapping), each MSB byte first.
  task automatic check_dump(input string tag, input logic [AW-1:0] f, input logic [AW-1:0] l,
                            input int tbl_words, input int exp_done);
    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic [DW-1:0] w;
    int n, a, mism;
    n = ((int'(l) - int'(f) + NW) % NW) + 1;
    for (int k = 0; k < n; k++) begin
      a = (int'(f) + k) % NW;
      exp_rd_q.push_back(AW'(a));
      w = mem[a];
      for (int b = 0; b < 4; b++) exp_q.push_back(w[31 - 8*b -: 8]);
    end
    check($sformatf("%s timeout", tag), int'(timed_out), 0);
    check($sformatf("%s nbytes", tag), got_q.size(), 4*n);
    if (tbl_words > 0) check($sformatf("%s nbytes_tbl", tag), got_q.size(), 4*tbl_words);
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check($sformatf("%s byte_mismatches", tag), mism, 0);
    check($sformatf("%s nreads", tag), rd_q.size(), n);
    mism = 0;
    for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++)
      if (rd_q[i] !== exp_rd_q[i]) mism++;
    check($sformatf("%s addr_mismatches", tag), mism, 0);
    check($sformatf("%s done_pulses", tag), done_cnt, 1);
    check($sformatf("%s last_count", tag), last_cnt, 1);
    check($sformatf("%s last_pos", tag), last_idx, 4*n - 1);
    check($sformatf("%s stall_errors", tag), stall_err, 0);
    check($sformatf("%s protocol_errors", tag), proto_err, 0);
    check($sformatf("%s first_rd_cycle", tag), first_rd, 1);
    check($sformatf("%s first_valid_cycle", tag), first_valid, 3);
    if (exp_done > 0) check($sformatf("%s done_cycle", tag), done_cyc, exp_done);
  endtask

  vec_t vecs[6];
  logic [AW-1:0] rf, rl;

  initial begin
    vecs[0] = '{f: 5'd3,  l: 5'd3,  mode: 0, restart_at: 0, mem_init: 1, exp_words: 1,  exp_done: 7};
    vecs[1] = '{f: 5'd0,  l: 5'd2,  mode: 1, restart_at: 0, mem_init: 1, exp_words: 3,  exp_done: 0};
    vecs[2] = '{f: 5'd30, l: 5'd1,  mode: 0, restart_at: 0, mem_init: 0, exp_words: 4,  exp_done: 25};
    vecs[3] = '{f: 5'd0,  l: 5'd31, mode: 0, restart_at: 0, mem_init: 0, exp_words: 32, exp_done: 193};
    vecs[4] = '{f: 5'd10, l: 5'd14, mode: 0, restart_at: 5, mem_init: 0, exp_words: 5,  exp_done: 31};
    vecs[5] = '{f: 5'd31, l: 5'd0,  mode: 2, restart_at: 0, mem_init: 1, exp_words: 2,  exp_done: 0};

    rst = 1'b1; i_start = 1'b0; i_first_addr = '0; i_last_addr = '0; i_out_ready = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset mem_addr",  int'(o_mem_addr), 0);
    check("reset mem_rd_en", int'(o_mem_rd_en), 0);
    check("reset out_data",  int'(o_out_data), 0);
    check("reset out_valid", int'(o_out_valid), 0);
    check("reset out_last",  int'(o_out_last), 0);
    check("reset busy_done", int'({o_busy, o_done}), 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NW; i++) mem[i] = (vecs[v].mem_init == 0) ? DW'(i) : DW'(i + 1);
      if (vecs[v].mem_init == 1) mem[3] = 32'hDEADBEEF;
      run_dump(vecs[v].f, vecs[v].l, vecs[v].mode, vecs[v].restart_at, 0);
      check_dump($sformatf("vec%0d", v), vecs[v].f, vecs[v].l, vecs[v].exp_words, vecs[v].exp_done);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      rf = AW'($urandom_range(0, NW - 1));
      rl = AW'($urandom_range(0, NW - 1));
      run_dump(rf, rl, 2, 0, 0);
      check_dump($sformatf("rand%0d", r), rf, rl, 0, 0);
    end

    // Reset once byte 2 of the second word has been accepted.
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    run_dump(5'd5, 5'd8, 0, 0, 7);
    check("abort timeout", int'(timed_out), 0);
    @(negedge clk);
    rst = 1'b1;
    i_out_ready = 1'b0;
    @(negedge clk);
    check("abort out_valid", int'(o_out_valid), 0);
    check("abort busy",      int'(o_busy), 0);
    check("abort rd_done",   int'({o_mem_rd_en, o_done, o_out_last}), 0);
    check("abort mem_addr",  int'(o_mem_addr), 0);
    rst = 1'b0;
    run_dump(5'd12, 5'd13, 0, 0, 0);
    check_dump("after_abort", 5'd12, 5'd13, 2, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
